// File: rtl/stim_sequencer.sv
// stim_sequencer: timed stimulus script player for HIL rigs.
// Optional feature macro: STIM_LOOP_EN (repeat script while loop=1).
module stim_sequencer #(
  parameter  int NUM_CH = 4,
  parameter  int CH_W   = 16,
  parameter  int DEPTH  = 16,
  parameter  int DLY_W  = 24,
  localparam int AW     = $clog2(DEPTH),
  localparam int CHS_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int STEP_W = DLY_W + 1 + 8 + 1 + CHS_W + CH_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [STEP_W-1:0]      wr_data,
  input  logic [AW:0]            num_steps,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   loop,
  input  logic                   tx_done,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  output logic [NUM_CH*CH_W-1:0] ch_out,
  output logic                   busy,
  output logic                   done,
  output logic [AW-1:0]          step_idx
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    APPLY,
    WAIT_TX,
    DELAY
  } state_t;

  state_t state_q, state_d;

  logic [STEP_W-1:0] mem [DEPTH];
  logic [STEP_W-1:0] step_q;
  logic [AW:0]       nsteps_q;
  logic [AW:0]       nsteps_clamp;
  logic [DLY_W-1:0]  cnt_q;
  logic [CH_W-1:0]   ch_q [NUM_CH];

  logic [DLY_W-1:0]  dly;
  logic              cmd_vld;
  logic [7:0]        cmd;
  logic              ch_wen;
  logic [CHS_W-1:0]  ch_sel;
  logic [CH_W-1:0]   ch_val;

  logic kill, go, zero_go, fetch, apply;
  logic send, ld_cnt, dec, nxt, wrap, fin;
  logic last, loop_ok;

  assign {dly, cmd_vld, cmd, ch_wen, ch_sel, ch_val} = step_q;

  assign last = ({1'b0, step_idx} == nsteps_q - (AW+1)'(1));

  assign nsteps_clamp = (num_steps > (AW+1)'(DEPTH))
                      ? (AW+1)'(DEPTH) : num_steps;

`ifdef STIM_LOOP_EN
  assign loop_ok = loop;
`else
  logic loop_unused;
  assign loop_ok     = 1'b0;
  assign loop_unused = loop;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_out[k*CH_W +: CH_W] = ch_q[k];
  end

  // Script store: host writes land in any state, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state plus per-cycle action strobes; abort beats everything.
  always_comb begin
    state_d = state_q;
    kill    = 1'b0;
    go      = 1'b0;
    zero_go = 1'b0;
    fetch   = 1'b0;
    apply   = 1'b0;
    send    = 1'b0;
    ld_cnt  = 1'b0;
    dec     = 1'b0;
    nxt     = 1'b0;
    wrap    = 1'b0;
    fin     = 1'b0;
    if (abort && state_q != IDLE) begin
      kill    = 1'b1;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            if (num_steps == '0) begin
              zero_go = 1'b1;
            end else begin
              go      = 1'b1;
              state_d = FETCH;
            end
          end
        end
        FETCH: begin
          fetch   = 1'b1;
          state_d = APPLY;
        end
        APPLY: begin
          apply = 1'b1;
          if (cmd_vld) begin
            send    = 1'b1;
            state_d = WAIT_TX;
          end else begin
            ld_cnt  = 1'b1;
            state_d = DELAY;
          end
        end
        WAIT_TX: begin
          if (tx_done) begin
            ld_cnt  = 1'b1;
            state_d = DELAY;
          end
        end
        DELAY: begin
          if (cnt_q != '0) begin
            dec = 1'b1;
          end else if (!last) begin
            nxt     = 1'b1;
            state_d = FETCH;
          end else if (loop_ok) begin
            wrap    = 1'b1;
            state_d = FETCH;
          end else begin
            fin     = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: step latch, counters, channel and UART outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      trmt     <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= '0;
      nsteps_q <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) ch_q[k] <= '0;
    end else begin
      trmt <= send;
      done <= fin | zero_go;
      if (go) begin
        nsteps_q <= nsteps_clamp;
        step_idx <= '0;
        busy     <= 1'b1;
      end
      if (nxt)        step_idx <= step_idx + AW'(1);
      if (wrap)       step_idx <= '0;
      if (fin | kill) busy     <= 1'b0;
      if (fetch)      step_q   <= mem[step_idx];
      if (send)       tx_data  <= cmd;
      if (ld_cnt)     cnt_q    <= dly;
      else if (dec)   cnt_q    <= cnt_q - DLY_W'(1);
      else if (kill)  cnt_q    <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        if (apply && ch_wen && ch_sel == CHS_W'(k))
          ch_q[k] <= ch_val;
      end
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer: directed checks for stim_sequencer.
// Three channels so an out-of-range ch_sel (3) is encodable.
module tb_stim_sequencer;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 16;
  localparam int DEPTH  = 16;
  localparam int DLY_W  = 24;
  localparam int AW     = 4;
  localparam int STEP_W = 52;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [STEP_W-1:0] wr_data;
  logic [AW:0]       num_steps;
  logic              start;
  logic              abort;
  logic              loop;
  logic              tx_done;
  logic              trmt;
  logic [7:0]        tx_data;
  logic [47:0]       ch_out;
  logic              busy;
  logic              done;
  logic [AW-1:0]     step_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stim_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W),
    .DEPTH(DEPTH), .DLY_W(DLY_W)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .num_steps(num_steps),
    .start(start), .abort(abort),
    .loop(loop), .tx_done(tx_done),
    .trmt(trmt), .tx_data(tx_data),
    .ch_out(ch_out), .busy(busy),
    .done(done), .step_idx(step_idx)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ch(input int k);
    return ch_out[k*16 +: 16];
  endfunction

  function automatic logic [STEP_W-1:0] mk(
    input logic [23:0] dly, input logic cv,
    input logic [7:0] cmd, input logic wen,
    input logic [1:0] sel, input logic [15:0] val);
    return {dly, cv, cmd, wen, sel, val};
  endfunction

  task automatic wr(input int a, input logic [STEP_W-1:0] w);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = w;
    tick;
    wr_en   = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic go(input int n);
    num_steps = (AW+1)'(n);
    start     = 1'b1;
    tick;
    start     = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    total++;
    if ({trmt, tx_data, ch_out, busy, done, step_idx} !== '0) begin
      bad++;
      $display("FAIL reset outs got=%h want=0",
               {trmt, tx_data, ch_out, busy, done, step_idx});
    end
  endtask

  task automatic test_three_steps;
    int t0, t1, t2, td, nd;
    t0 = -1; t1 = -1; t2 = -1; td = -1; nd = 0;
    do_reset;
    wr(0, mk(10, 0, 0, 1, 0, 16'h0300));
    wr(1, mk(10, 0, 0, 1, 1, 16'h0300));
    wr(2, mk(0, 0, 0, 1, 2, 16'h0FFF));
    go(3);
    for (int c = 1; c <= 60; c++) begin
      tick;
      if (t0 < 0 && ch(0) == 16'h0300) t0 = c;
      if (t1 < 0 && ch(1) == 16'h0300) t1 = c;
      if (t2 < 0 && ch(2) == 16'h0FFF) t2 = c;
      if (done) begin
        nd++;
        if (td < 0) td = c;
      end
    end
    total++;
    if (t0 !== 2) begin
      bad++; $display("FAIL seq ch0 time got=%0d want=2", t0);
    end
    total++;
    if (t1 - t0 !== 13) begin
      bad++; $display("FAIL seq gap01 got=%0d want=13", t1 - t0);
    end
    total++;
    if (t2 - t1 !== 13) begin
      bad++; $display("FAIL seq gap12 got=%0d want=13", t2 - t1);
    end
    total++;
    if (td !== 29) begin
      bad++; $display("FAIL seq done time got=%0d want=29", td);
    end
    total++;
    if (nd !== 1) begin
      bad++; $display("FAIL seq done count got=%0d want=1", nd);
    end
    total++;
    if (busy !== 1'b0 || step_idx !== 4'd2) begin
      bad++;
      $display("FAIL seq end busy/idx got=%b/%0d want=0/2",
               busy, step_idx);
    end
  endtask

  task automatic test_cmd_wait;
    int ntr, moved, tc;
    ntr = 0; moved = 0; tc = -1;
    do_reset;
    wr(0, mk(0, 1, 8'h47, 0, 0, 16'h0));
    tx_done = 1'b0;
    go(1);
    for (int c = 1; c <= 102; c++) begin
      tick;
      if (trmt) begin
        ntr++;
        if (tc < 0) tc = c;
      end
      if (step_idx !== 4'd0 || busy !== 1'b1 || done !== 1'b0)
        moved++;
    end
    total++;
    if (ntr !== 1 || tc !== 2) begin
      bad++;
      $display("FAIL cmd trmt cnt/time got=%0d/%0d want=1/2",
               ntr, tc);
    end
    total++;
    if (tx_data !== 8'h47) begin
      bad++; $display("FAIL cmd tx_data got=%h want=47", tx_data);
    end
    total++;
    if (moved !== 0) begin
      bad++; $display("FAIL cmd frozen got=%0d want=0", moved);
    end
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL cmd post txdone got=%b%b want=01", done, busy);
    end
    tick;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || tx_data !== 8'h47) begin
      bad++;
      $display("FAIL cmd finish got=%b%b %h want=10 47",
               done, busy, tx_data);
    end
    tick;
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL cmd done pulse got=%b want=0", done);
    end
  endtask

  task automatic test_abort;
    int n, act;
    do_reset;
    wr(0, mk(2, 0, 0, 1, 0, 16'h0011));
    wr(1, mk(1000, 0, 0, 1, 1, 16'h0022));
    wr(2, mk(0, 0, 0, 1, 2, 16'h0033));
    go(3);
    n = 0;
    while (ch(1) != 16'h0022 && n < 50) begin
      tick;
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++; $display("FAIL abort reach step1 got=timeout want=<50");
    end
    repeat (5) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort busy/done got=%b%b want=00", busy, done);
    end
    total++;
    if (ch_out !== {16'h0, 16'h0022, 16'h0011}) begin
      bad++;
      $display("FAIL abort ch hold got=%h want=%h",
               ch_out, {16'h0, 16'h0022, 16'h0011});
    end
    act = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (done || busy || trmt) act++;
    end
    total++;
    if (act !== 0) begin
      bad++; $display("FAIL abort quiet got=%0d want=0", act);
    end
    num_steps = 5'd3;
    abort = 1'b1;
    start = 1'b1;
    tick;
    abort = 1'b0;
    start = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL abort+start busy got=%b want=0", busy);
    end
    go(3);
    total++;
    if (busy !== 1'b1 || step_idx !== 4'd0) begin
      bad++;
      $display("FAIL abort replay got=%b/%0d want=1/0",
               busy, step_idx);
    end
    n = 0;
    while (step_idx != 4'd1 && n < 50) begin
      tick;
      n++;
    end
    go(3);
    total++;
    if (step_idx !== 4'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL start while busy idx got=%0d want=1", step_idx);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_loop;
    int nd, nd2, wraps;
    logic [AW-1:0] prev;
    int exp_nd, exp_nd2;
    logic exp_wrap, exp_busy;
`ifdef STIM_LOOP_EN
    exp_nd = 0; exp_nd2 = 1; exp_wrap = 1'b1; exp_busy = 1'b1;
`else
    exp_nd = 1; exp_nd2 = 0; exp_wrap = 1'b0; exp_busy = 1'b0;
`endif
    nd = 0; nd2 = 0; wraps = 0;
    do_reset;
    wr(0, mk(1, 0, 0, 1, 0, 16'h000A));
    wr(1, mk(1, 0, 0, 1, 0, 16'h000B));
    loop = 1'b1;
    go(2);
    prev = step_idx;
    for (int c = 1; c <= 30; c++) begin
      tick;
      if (done) nd++;
      if (prev == 4'd1 && step_idx == 4'd0) wraps++;
      prev = step_idx;
    end
    total++;
    if (nd !== exp_nd || (wraps != 0) !== exp_wrap) begin
      bad++;
      $display("FAIL loop pass done/wraps got=%0d/%0d want=%0d/%b",
               nd, wraps, exp_nd, exp_wrap);
    end
    total++;
    if (busy !== exp_busy) begin
      bad++; $display("FAIL loop busy got=%b want=%b", busy, exp_busy);
    end
    loop = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (done) nd2++;
    end
    total++;
    if (nd2 !== exp_nd2 || busy !== 1'b0 || step_idx !== 4'd1) begin
      bad++;
      $display("FAIL loop drop got=%0d/%b/%0d want=%0d/0/1",
               nd2, busy, step_idx, exp_nd2);
    end
  endtask

  task automatic test_zero_steps;
    do_reset;
    go(0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero steps got=%b%b want=10", done, busy);
    end
    tick;
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || ch_out !== '0) begin
      bad++;
      $display("FAIL zero after got=%b%b %h want=00 0",
               done, busy, ch_out);
    end
  endtask

  task automatic test_clamp;
    int td;
    td = -1;
    do_reset;
    for (int a = 0; a < 16; a++) wr(a, mk(0, 0, 0, 1, 0, 16'(a)));
    go(20);
    for (int c = 1; c <= 70; c++) begin
      tick;
      if (done && td < 0) td = c;
    end
    total++;
    if (td !== 48 || step_idx !== 4'd15 || ch(0) !== 16'd15) begin
      bad++;
      $display("FAIL clamp got=%0d/%0d/%h want=48/15/000f",
               td, step_idx, ch(0));
    end
  endtask

  task automatic test_bad_sel;
    int n;
    do_reset;
    wr(0, mk(0, 0, 0, 1, 0, 16'h0055));
    wr(1, mk(0, 0, 0, 1, 3, 16'hBEEF));
    go(2);
    n = 0;
    while (!done && n < 30) begin
      tick;
      n++;
    end
    total++;
    if (n >= 30 || ch_out !== {16'h0, 16'h0, 16'h0055}) begin
      bad++;
      $display("FAIL bad sel got=%h n=%0d want=%h",
               ch_out, n, {16'h0, 16'h0, 16'h0055});
    end
  endtask

  task automatic test_rst_mid;
    do_reset;
    wr(0, mk(5, 1, 8'h5A, 1, 1, 16'h0077));
    go(1);
    tick;
    tick;
    total++;
    if (trmt !== 1'b1 || ch(1) !== 16'h0077) begin
      bad++;
      $display("FAIL rst pre got=%b %h want=1 0077", trmt, ch(1));
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if ({trmt, tx_data, ch_out, busy, done, step_idx} !== '0) begin
      bad++;
      $display("FAIL rst mid got=%h want=0",
               {trmt, tx_data, ch_out, busy, done, step_idx});
    end
  endtask

  task automatic test_rewrite;
    int n;
    do_reset;
    wr(0, mk(20, 0, 0, 1, 0, 16'h0001));
    wr(1, mk(0, 0, 0, 1, 1, 16'h0002));
    wr(2, mk(0, 0, 0, 1, 2, 16'h0AAA));
    go(3);
    repeat (3) tick;
    wr(2, mk(0, 0, 0, 1, 2, 16'h0BBB));
    n = 0;
    while (!done && n < 60) begin
      tick;
      n++;
    end
    total++;
    if (n >= 60 || ch_out !== {16'h0BBB, 16'h0002, 16'h0001}) begin
      bad++;
      $display("FAIL rewrite got=%h n=%0d want=%h",
               ch_out, n, {16'h0BBB, 16'h0002, 16'h0001});
    end
  endtask

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    num_steps = '0;
    start     = 1'b0;
    abort     = 1'b0;
    loop      = 1'b0;
    tx_done   = 1'b0;
    test_reset;
    test_three_steps;
    test_cmd_wait;
    test_abort;
    test_loop;
    test_zero_steps;
    test_clamp;
    test_bad_sel;
    test_rst_mid;
    test_rewrite;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
